// File: rtl/vote_pkg.sv
// Shared definitions for the 4-voter round controller and its evaluator.
package vote_pkg;
  localparam int N_VOTERS       = 4;
  localparam int VOTE_THRESHOLD = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EVAL    = 2'd2,
    S_DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/vote_eval_3of4.sv
// Combinational 3-of-4 evaluator: popcount of the vote vector and threshold pass.
module vote_eval_3of4
  import vote_pkg::*;
(
  input  logic [N_VOTERS-1:0] votes,
  output logic                pass,
  output logic [2:0]          count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < N_VOTERS; i++) count = count + {2'b00, votes[i]};
  end

  assign pass = (count >= 3'(VOTE_THRESHOLD));
endmodule

// File: rtl/vote_round_ctrl.sv
// Voting-round sequencer: collects one vote per voter with a bounded timeout,
// evaluates 3-of-4 on the captured votes and holds the result until acked.
module vote_round_ctrl
  import vote_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_val,
  output logic [N_VOTERS-1:0] vote_ack,
  output logic                busy,
  output logic                result_valid,
  output logic                result,
  output logic [2:0]          yes_count,
  output logic                timed_out,
  input  logic                result_ack
);
  state_e              state_q;
  logic [CW-1:0]       timer_q;
  logic [N_VOTERS-1:0] got_q, vote_q, ack_q;
  logic                busy_q, rv_q, res_q, to_q;
  logic [2:0]          cnt_q;

  logic [N_VOTERS-1:0] cap, got_d, vote_d;
  logic                ev_pass;
  logic [2:0]          ev_cnt;

  // Only first valid per voter in COLLECT is captured; repeats are dropped.
  assign cap    = (state_q == S_COLLECT) ? (vote_valid & ~got_q) : '0;
  assign got_d  = got_q | cap;
  assign vote_d = (vote_q & ~cap) | (vote_val & cap);

  vote_eval_3of4 u_eval (
    .votes (vote_q),
    .pass  (ev_pass),
    .count (ev_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      got_q   <= '0;
      vote_q  <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      res_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ack_q <= cap;
      case (state_q)
        S_IDLE: if (start) begin
          got_q   <= '0;
          vote_q  <= '0;
          timer_q <= '0;
          to_q    <= 1'b0;
          res_q   <= 1'b0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_COLLECT;
        end
        S_COLLECT: begin
          got_q  <= got_d;
          vote_q <= vote_d;
          // A full set on the timeout edge is a normal completion, not a timeout.
          if (&got_d) begin
            state_q <= S_EVAL;
          end else if (timer_q == CW'(TIMEOUT - 1)) begin
            state_q <= S_EVAL;
            to_q    <= 1'b1;
          end else begin
            timer_q <= timer_q + CW'(1);
          end
        end
        S_EVAL: begin
          res_q   <= ev_pass;
          cnt_q   <= ev_cnt;
          rv_q    <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: if (result_ack) begin
          rv_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vote_ack     = ack_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign result       = res_q;
  assign yes_count    = cnt_q;
  assign timed_out    = to_q;
endmodule

// File: tb/tb_vote_round_ctrl.sv
// Randomized bench for vote_round_ctrl against an arrival-time model of a round.
module tb_vote_round_ctrl;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst, start, result_ack;
  logic [3:0] vote_valid, vote_val, vote_ack;
  logic       busy, result_valid, result, timed_out;
  logic [2:0] yes_count;

  int n_chk = 0;
  int n_err = 0;

  // Round description: voter i raises valid in COLLECT cycle arr_a[i] and
  // keeps it up arr_h[i] extra cycles; arr_v is the vote value.
  int         arr_a[4];
  int         arr_h[4];
  logic [3:0] arr_v;
  int         ack_wait;
  bit         ack_stick;

  vote_round_ctrl #(.TIMEOUT(TO), .CW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vote_valid   (vote_valid),
    .vote_val     (vote_val),
    .vote_ack     (vote_ack),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .yes_count    (yes_count),
    .timed_out    (timed_out),
    .result_ack   (result_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_round();
    int         e, yes;
    bit         all_in;
    logic [3:0] capd, exp_ack;
    int         exp_res;
    all_in = 1'b1;
    e      = 0;
    for (int i = 0; i < 4; i++) begin
      if (arr_a[i] > TO - 1) all_in = 1'b0;
      else if (arr_a[i] > e) e = arr_a[i];
    end
    if (!all_in) e = TO - 1;
    yes  = 0;
    capd = '0;
    for (int i = 0; i < 4; i++)
      if (arr_a[i] <= e) begin
        capd[i] = 1'b1;
        if (arr_v[i]) yes++;
      end
    exp_res = (yes >= 3) ? 1 : 0;

    chk("idle_busy", busy, 0);
    chk("idle_rv", result_valid, 0);
    start    = 1'b1;
    vote_val = arr_v;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= e + 2; c++) begin
      for (int i = 0; i < 4; i++) exp_ack[i] = capd[i] && (arr_a[i] + 1 == c);
      chk("ack", vote_ack, exp_ack);
      chk("rv", result_valid, (c >= e + 2) ? 1 : 0);
      chk("busy", busy, 1);
      for (int i = 0; i < 4; i++)
        vote_valid[i] = (c >= arr_a[i]) && (c <= arr_a[i] + arr_h[i]);
      start = (c < e + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c < e + 2) @(negedge clk);
    end
    chk("result", result, exp_res);
    chk("yes_count", yes_count, yes);
    chk("timed_out", timed_out, all_in ? 0 : 1);
    for (int j = 0; j < ack_wait; j++) begin
      vote_valid = 4'($urandom);
      @(negedge clk);
      chk("hold_rv", result_valid, 1);
      chk("hold_res", result, exp_res);
      chk("hold_ack", vote_ack, 0);
    end
    vote_valid = '0;
    result_ack = 1'b1;
    @(negedge clk);
    if (!ack_stick) result_ack = 1'b0;
    chk("post_busy", busy, 0);
    chk("post_rv", result_valid, 0);
    chk("post_res", result, exp_res);
    chk("post_cnt", yes_count, yes);
    if (ack_stick) begin
      @(negedge clk);
      @(negedge clk);
      result_ack = 1'b0;
      chk("stick_busy", busy, 0);
      chk("stick_rv", result_valid, 0);
    end
  endtask

  task automatic rst_mid();
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    vote_valid = 4'b0101;
    vote_val   = 4'b0101;
    @(negedge clk);
    vote_valid = 4'b0000;
    chk("mid_ack", vote_ack, 4'b0101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ack", vote_ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rv", result_valid, 0);
    chk("mid_rst_res", {result, yes_count, timed_out}, 0);
    @(negedge clk);
    chk("mid_after_rv", result_valid, 0);
    chk("mid_after_busy", busy, 0);
  endtask

  task automatic set_round(input int a0, a1, a2, a3, input int h0, input logic [3:0] v,
                           input int w, input bit s);
    arr_a[0] = a0; arr_a[1] = a1; arr_a[2] = a2; arr_a[3] = a3;
    arr_h[0] = h0; arr_h[1] = 0;  arr_h[2] = 0;  arr_h[3] = 0;
    arr_v = v; ack_wait = w; ack_stick = s;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; result_ack = 1'b0;
    vote_valid = '0; vote_val = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", vote_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_res", {result, yes_count, timed_out}, 0);
    rst = 1'b0;
    @(negedge clk);

    set_round(0, 0, 0, 0, 0, 4'b1011, 0, 0);  run_round();  // all four at once
    set_round(0, 2, 1, 3, 3, 4'b1111, 1, 0);  run_round();  // staggered
    set_round(0, 0, 99, 99, 0, 4'b0011, 2, 1); run_round(); // timeout
    set_round(0, 1, 2, TO-1, 1, 4'b1111, 0, 0); run_round(); // timeout-edge capture
    set_round(3, 1, 0, 2, 0, 4'b0110, 10, 0); run_round();  // long result hold
    rst_mid();

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 4; i++) begin
        arr_a[i] = (r % 2 == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, TO + 3);
        arr_h[i] = $urandom_range(0, 3);
      end
      arr_v     = 4'($urandom);
      ack_wait  = $urandom_range(0, 4);
      ack_stick = 1'($urandom_range(0, 1));
      run_round();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
